// File: rtl/remote_decoder_param_pkg.sv
// rtl/remote_decoder_param_pkg.sv - shared types, frame geometry helpers for the remote decoder
package remote_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  // Inverted-key field always occupies the least significant bits of the frame word
  localparam int INV_LSB = 0;

  function automatic int frame_len(input int custom_w, input int key_w);
    return custom_w + 2 * key_w;
  endfunction

  // Key field sits directly above the inverted-key field
  function automatic int key_lsb(input int key_w);
    return INV_LSB + key_w;
  endfunction

  // Custom code is the most significant field
  function automatic int cust_lsb(input int key_w);
    return INV_LSB + 2 * key_w;
  endfunction

endpackage

// File: rtl/remote_decoder_param_if.sv
// rtl/remote_decoder_param_if.sv - serial input and decoded-key outputs of the remote decoder
interface remote_decoder_param_if #(
  parameter int CUSTOM_W = 16,
  parameter int KEY_W    = 8
);
  logic                serial;
  logic                ready;
  logic [KEY_W-1:0]    remote_key;
  logic [CUSTOM_W-1:0] custom_code;
  logic                error;
  logic                repeat_key;

  // Decoder side: consumes the line, produces the decoded frame
  modport master (
    input  serial,
    output ready, remote_key, custom_code, error, repeat_key
  );

  // Line sampler / key handler side
  modport slave (
    output serial,
    input  ready, remote_key, custom_code, error, repeat_key
  );
endinterface

// File: rtl/remote_frame_shifter.sv
// rtl/remote_frame_shifter.sv - serial-in/parallel-out frame register with bit counter
module remote_frame_shifter #(
  parameter int F = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         serial,
  output logic [F-1:0] frame,
  output logic         done
);
  localparam int CW = $clog2(F + 1);

  // Only F-1 bits need storing: the newest bit comes straight from the line
  logic [F-2:0]  sreg;
  logic [CW-1:0] count;

  // Frame as it will look once the current bit is shifted in, so the
  // checker can evaluate in the same cycle the last bit is sampled
  assign frame = {sreg, serial};
  assign done  = shift_en && (count == CW'(F - 1));

  // Shift register and bit counter; counter rewinds on clear and after the last bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (shift_en) begin
      sreg  <= frame[F-2:0];
      count <= done ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/remote_decoder_param.sv
// rtl/remote_decoder_param.sv - parametrised IR remote frame decoder with ID check and repeat flag
module remote_decoder_param
  import remote_pkg::*;
#(
  parameter int                  CUSTOM_W  = 16,
  parameter int                  KEY_W     = 8,
  parameter logic [CUSTOM_W-1:0] CUSTOM_ID = CUSTOM_W'(16'hAAAA),
  parameter bit                  CHECK_ID  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  remote_decoder_param_if.master bus
);
  localparam int F        = frame_len(CUSTOM_W, KEY_W);
  localparam int KEY_LSB  = key_lsb(KEY_W);
  localparam int CUST_LSB = cust_lsb(KEY_W);

  state_t              state;
  logic                ready_r;
  logic                error_r;
  logic                repeat_r;
  logic                have_prev;
  logic [KEY_W-1:0]    key_r;
  logic [CUSTOM_W-1:0] cust_r;

  logic [F-1:0]        frame;
  logic                done;
  logic                clear;
  logic                shift_en;
  logic [KEY_W-1:0]    key_f;
  logic [KEY_W-1:0]    inv_f;
  logic [CUSTOM_W-1:0] cust_f;
  logic                key_ok;
  logic                id_ok;
  logic                ok;

  // The start marker clears the counter; every S_DATA cycle is a data bit
  assign clear    = (state == S_START) && bus.serial;
  assign shift_en = (state == S_DATA);

  remote_frame_shifter #(
    .F(F)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (shift_en),
    .serial   (bus.serial),
    .frame    (frame),
    .done     (done)
  );

  // Field extraction and frame validation on the complete word
  assign key_f  = frame[KEY_LSB +: KEY_W];
  assign inv_f  = frame[INV_LSB +: KEY_W];
  assign cust_f = frame[CUST_LSB +: CUSTOM_W];
  assign key_ok = (key_f == ~inv_f);
  assign id_ok  = !CHECK_ID || (cust_f == CUSTOM_ID);
  assign ok     = key_ok && id_ok;

  // Frame FSM with registered result pulses and last-valid-frame holding registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      ready_r   <= 1'b0;
      error_r   <= 1'b0;
      repeat_r  <= 1'b0;
      have_prev <= 1'b0;
      key_r     <= '0;
      cust_r    <= '0;
    end else begin
      ready_r  <= 1'b0;
      error_r  <= 1'b0;
      repeat_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.serial) state <= S_START;
        end
        S_START: begin
          if (bus.serial) state <= S_DATA;
        end
        S_DATA: begin
          if (done) begin
            state <= S_IDLE;
            if (ok) begin
              ready_r   <= 1'b1;
              repeat_r  <= have_prev && (key_f == key_r);
              key_r     <= key_f;
              cust_r    <= cust_f;
              have_prev <= 1'b1;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready       = ready_r;
  assign bus.error       = error_r;
  assign bus.repeat_key  = repeat_r;
  assign bus.remote_key  = key_r;
  assign bus.custom_code = cust_r;
endmodule

// File: tb/tb_remote_decoder_param.sv
// tb/tb_remote_decoder_param.sv - directed self-checking bench for remote_decoder_param
module tb_remote_decoder_param;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  remote_decoder_param_if #(.CUSTOM_W(16), .KEY_W(8))  bus0 ();
  remote_decoder_param_if #(.CUSTOM_W(16), .KEY_W(8))  bus1 ();
  remote_decoder_param_if #(.CUSTOM_W(8),  .KEY_W(12)) bus2 ();

  logic s01;
  assign bus0.serial = s01;
  assign bus1.serial = s01;

  remote_decoder_param dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  remote_decoder_param #(
    .CHECK_ID (1'b0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  remote_decoder_param #(
    .CUSTOM_W  (8),
    .KEY_W     (12),
    .CUSTOM_ID (8'hC3)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Low gap, start marker, then 32 bits MSB first on the shared line of dut0/dut1
  task automatic send01(input logic [15:0] c, input logic [7:0] k, input logic [7:0] iv, input int gap);
    logic [31:0] w;
    w = {c, k, iv};
    s01 = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    s01 = 1'b1;
    tick();
    for (int i = 31; i >= 0; i--) begin
      s01 = w[i];
      tick();
    end
    s01 = 1'b1;
  endtask

  task automatic send2(input logic [7:0] c, input logic [11:0] k, input logic [11:0] iv);
    logic [31:0] w;
    w = {c, k, iv};
    bus2.serial = 1'b0;
    tick();
    bus2.serial = 1'b1;
    tick();
    for (int i = 31; i >= 0; i--) begin
      bus2.serial = w[i];
      tick();
    end
    bus2.serial = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    s01         = 1'b1;
    bus2.serial = 1'b1;
    reset       = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'd0, bus0.ready}, 32'd0);
    chk("rst_error", {31'd0, bus0.error}, 32'd0);
    chk("rst_repeat", {31'd0, bus0.repeat_key}, 32'd0);
    chk("rst_key", {24'd0, bus0.remote_key}, 32'd0);
    chk("rst_cust", {16'd0, bus0.custom_code}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: first valid frame
    send01(16'hAAAA, 8'h81, 8'h7E, 1);
    chk("t1_ready", {31'd0, bus0.ready}, 32'd1);
    chk("t1_key", {24'd0, bus0.remote_key}, 32'h81);
    chk("t1_cust", {16'd0, bus0.custom_code}, 32'hAAAA);
    chk("t1_repeat", {31'd0, bus0.repeat_key}, 32'd0);
    chk("t1_error", {31'd0, bus0.error}, 32'd0);
    tick();
    chk("t1_ready_pulse", {31'd0, bus0.ready}, 32'd0);

    // 2: inverse mismatch, with an idle-low gap before the marker
    send01(16'hAAAA, 8'h89, 8'h7E, 3);
    chk("t2_error", {31'd0, bus0.error}, 32'd1);
    chk("t2_ready", {31'd0, bus0.ready}, 32'd0);
    chk("t2_key", {24'd0, bus0.remote_key}, 32'h81);
    tick();
    chk("t2_error_pulse", {31'd0, bus0.error}, 32'd0);

    // 3: repeat of previous valid key, then a new key
    send01(16'hAAAA, 8'h81, 8'h7E, 1);
    chk("t3_ready", {31'd0, bus0.ready}, 32'd1);
    chk("t3_repeat", {31'd0, bus0.repeat_key}, 32'd1);
    tick();
    chk("t3_repeat_pulse", {31'd0, bus0.repeat_key}, 32'd0);
    send01(16'hAAAA, 8'h42, 8'hBD, 2);
    chk("t3b_ready", {31'd0, bus0.ready}, 32'd1);
    chk("t3b_repeat", {31'd0, bus0.repeat_key}, 32'd0);
    chk("t3b_key", {24'd0, bus0.remote_key}, 32'h42);
    tick();

    // 4: foreign custom code, rejected with ID check, accepted without
    send01(16'h5555, 8'h24, 8'hDB, 1);
    chk("t4_id_error", {31'd0, bus0.error}, 32'd1);
    chk("t4_id_ready", {31'd0, bus0.ready}, 32'd0);
    chk("t4_id_cust", {16'd0, bus0.custom_code}, 32'hAAAA);
    chk("t4_noid_ready", {31'd0, bus1.ready}, 32'd1);
    chk("t4_noid_error", {31'd0, bus1.error}, 32'd0);
    chk("t4_noid_cust", {16'd0, bus1.custom_code}, 32'h5555);
    chk("t4_noid_key", {24'd0, bus1.remote_key}, 32'h24);
    tick();

    // 5: reset after 10 data bits of a frame, then a clean frame
    s01 = 1'b0;
    tick();
    s01 = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      s01 = i[0];
      tick();
    end
    reset = 1'b0;
    tick();
    chk("t5_ready", {31'd0, bus0.ready}, 32'd0);
    chk("t5_error", {31'd0, bus0.error}, 32'd0);
    chk("t5_key", {24'd0, bus0.remote_key}, 32'd0);
    chk("t5_cust", {16'd0, bus0.custom_code}, 32'd0);
    chk("t5_cust1", {16'd0, bus1.custom_code}, 32'd0);
    reset = 1'b1;
    s01   = 1'b1;
    tick();
    chk("t5_no_pulse", {30'd0, bus0.ready, bus0.error}, 32'd0);
    send01(16'hAAAA, 8'h81, 8'h7E, 1);
    chk("t5b_ready", {31'd0, bus0.ready}, 32'd1);
    chk("t5b_key", {24'd0, bus0.remote_key}, 32'h81);
    chk("t5b_repeat", {31'd0, bus0.repeat_key}, 32'd0);
    tick();

    // 6: alternate geometry 8/12/12
    send2(8'hC3, 12'hA5C, 12'h5A3);
    chk("t6_ready", {31'd0, bus2.ready}, 32'd1);
    chk("t6_key", {20'd0, bus2.remote_key}, 32'hA5C);
    chk("t6_cust", {24'd0, bus2.custom_code}, 32'hC3);
    tick();
    send2(8'hC3, 12'hA5C, 12'h5A2);
    chk("t6b_error", {31'd0, bus2.error}, 32'd1);
    chk("t6b_ready", {31'd0, bus2.ready}, 32'd0);
    chk("t6b_key", {20'd0, bus2.remote_key}, 32'hA5C);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
